// File: rtl/wheel_pwm_pkg.sv
// Shared types, constants and arithmetic helpers for the two-channel wheel PWM driver.
package wheel_pwm_pkg;

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_FWD  = 2'd1,
      ST_REV  = 2'd2,
      ST_DEAD = 2'd3
   } ch_state_t;

   localparam logic [6:0] PWM_MAX     = 7'd127;
   localparam logic [6:0] PERIOD_LAST = 7'd126;
   localparam logic       DIR_FWD     = 1'b0;
   localparam logic       DIR_REV     = 1'b1;

   // |cmd| saturated to PWM_MAX so that -128 maps to 127.
   function automatic logic [6:0] cmd_magnitude(input logic [7:0] cmd);
      logic [7:0] mag;
      mag = cmd[7] ? (8'd0 - cmd) : cmd;
      if (mag > {1'b0, PWM_MAX}) begin
         return PWM_MAX;
      end
      return mag[6:0];
   endfunction

   // Move cur toward goal by at most step without overshoot, clamped to 0..PWM_MAX.
   function automatic logic [6:0] slew_toward(input logic [6:0] cur, input logic [6:0] goal,
                                              input logic [7:0] step);
      logic [7:0] diff;
      logic [7:0] res;
      if (goal >= cur) begin
         diff = {1'b0, goal} - {1'b0, cur};
         res  = (diff > step) ? ({1'b0, cur} + step) : {1'b0, goal};
      end else begin
         diff = {1'b0, cur} - {1'b0, goal};
         res  = (diff > step) ? ({1'b0, cur} - step) : {1'b0, goal};
      end
      if (res > {1'b0, PWM_MAX}) begin
         return PWM_MAX;
      end
      return res[6:0];
   endfunction

endpackage

// File: rtl/wheel_pwm_channel.sv
// One H-bridge channel: target extraction, slew limiting, dead-time FSM and PWM compare.
//
// state | meaning
// ------+---------------------------------------------------------------
// STOP  | bridge idle, duty held at 0, waiting for a non-zero target
// FWD   | driving forward (dir=0), duty slewing toward the target
// REV   | driving reverse (dir=1), duty slewing toward the target
// DEAD  | output forced low for whole periods before reversing direction
module wheel_pwm_channel
   import wheel_pwm_pkg::*;
#(
   parameter int SLEW_STEP    = 8,
   parameter int DEAD_PERIODS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       period_cond,
   input  logic [6:0] period_cnt,
   input  logic [7:0] wheel,
   output logic       pwm,
   output logic       dir,
   output logic       dead
);

   localparam int            DW        = $clog2(DEAD_PERIODS + 1);
   localparam logic [7:0]    STEP8     = 8'(SLEW_STEP);
   localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_PERIODS);
   localparam logic [DW-1:0] DEAD_ONE  = DW'(1);

   ch_state_t     state, state_nxt;
   logic [6:0]    duty, duty_nxt;
   logic [DW-1:0] dead_cnt, dead_nxt;
   logic          dir_nxt;
   logic          pwm_nxt;

   logic [6:0] tgt_mag;
   logic       tgt_fwd;
   logic       tgt_rev;
   logic [6:0] duty_to_tgt;
   logic [6:0] duty_to_zero;
   logic [6:0] duty_first;

   assign tgt_mag      = cmd_magnitude(wheel);
   assign tgt_rev      = wheel[7];
   assign tgt_fwd      = ~wheel[7] && (wheel != 8'd0);
   assign duty_to_tgt  = slew_toward(duty, tgt_mag, STEP8);
   assign duty_to_zero = slew_toward(duty, 7'd0, STEP8);
   assign duty_first   = slew_toward(7'd0, tgt_mag, STEP8);

   // State register plus the registered pwm/dir pins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_STOP;
         duty     <= '0;
         dead_cnt <= '0;
         dir      <= DIR_FWD;
         pwm      <= 1'b0;
      end else begin
         state    <= state_nxt;
         duty     <= duty_nxt;
         dead_cnt <= dead_nxt;
         dir      <= dir_nxt;
         pwm      <= pwm_nxt;
      end
   end

   // Next-state: disable overrides everything; otherwise decisions are made once per period.
   always_comb begin
      state_nxt = state;
      duty_nxt  = duty;
      dead_nxt  = dead_cnt;
      dir_nxt   = dir;
      if (!enable) begin
         state_nxt = ST_STOP;
         duty_nxt  = '0;
         dead_nxt  = '0;
      end else if (period_cond) begin
         case (state)
            ST_STOP: begin
               duty_nxt = '0;
               if (tgt_fwd) begin
                  state_nxt = ST_FWD;
                  dir_nxt   = DIR_FWD;
                  duty_nxt  = duty_first;
               end else if (tgt_rev) begin
                  state_nxt = ST_REV;
                  dir_nxt   = DIR_REV;
                  duty_nxt  = duty_first;
               end
            end
            ST_FWD, ST_REV: begin
               if ((state == ST_FWD && tgt_fwd) || (state == ST_REV && tgt_rev)) begin
                  duty_nxt = duty_to_tgt;
               end else begin
                  duty_nxt = duty_to_zero;
                  if (duty_to_zero == 7'd0) begin
                     if (tgt_fwd || tgt_rev) begin
                        state_nxt = ST_DEAD;
                        dead_nxt  = DEAD_INIT;
                     end else begin
                        state_nxt = ST_STOP;
                     end
                  end
               end
            end
            ST_DEAD: begin
               // Expiry also covers a zero count so the counter can never wrap.
               if (dead_cnt <= DEAD_ONE) begin
                  dead_nxt = '0;
                  duty_nxt = '0;
                  if (tgt_fwd) begin
                     state_nxt = ST_FWD;
                     dir_nxt   = DIR_FWD;
                     duty_nxt  = duty_first;
                  end else if (tgt_rev) begin
                     state_nxt = ST_REV;
                     dir_nxt   = DIR_REV;
                     duty_nxt  = duty_first;
                  end else begin
                     state_nxt = ST_STOP;
                  end
               end else begin
                  dead_nxt = dead_cnt - DEAD_ONE;
               end
            end
            default: begin
               state_nxt = ST_STOP;
               duty_nxt  = '0;
               dead_nxt  = '0;
            end
         endcase
      end
   end

   // Outputs: PWM compare against the shared period counter, and the DEAD flag for busy.
   always_comb begin
      pwm_nxt = (period_cnt < duty) && (state == ST_FWD || state == ST_REV) && enable;
      dead    = (state == ST_DEAD);
   end

endmodule

// File: rtl/wheel_pwm_driver.sv
// Two-channel wheel PWM driver: shared prescaler and period counter feeding two channels.
module wheel_pwm_driver
   import wheel_pwm_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int SLEW_STEP    = 8,
   parameter int DEAD_PERIODS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] wheel_left,
   input  logic [7:0] wheel_right,
   output logic       pwm_left,
   output logic       dir_left,
   output logic       pwm_right,
   output logic       dir_right,
   output logic       period_start,
   output logic       busy
);

   localparam int            PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] presc;
   logic [6:0]    period_cnt;
   logic          tick;
   logic          period_cond;
   logic          dead_left;
   logic          dead_right;

   assign tick        = (presc == DIV_LAST);
   assign period_cond = tick && (period_cnt == PERIOD_LAST);

   // Prescaler: free-running, unaffected by enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Period counter 0..126; one period is 127 ticks.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period_cnt <= '0;
      end else if (tick) begin
         period_cnt <= (period_cnt == PERIOD_LAST) ? 7'd0 : period_cnt + 7'd1;
      end
   end

   // Registered status: period_start lands on the cycle the counter reads 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period_start <= 1'b0;
         busy         <= 1'b0;
      end else begin
         period_start <= period_cond;
         busy         <= dead_left | dead_right;
      end
   end

   wheel_pwm_channel #(
      .SLEW_STEP    (SLEW_STEP),
      .DEAD_PERIODS (DEAD_PERIODS)
   ) u_left (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .period_cond (period_cond),
      .period_cnt  (period_cnt),
      .wheel       (wheel_left),
      .pwm         (pwm_left),
      .dir         (dir_left),
      .dead        (dead_left)
   );

   wheel_pwm_channel #(
      .SLEW_STEP    (SLEW_STEP),
      .DEAD_PERIODS (DEAD_PERIODS)
   ) u_right (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .period_cond (period_cond),
      .period_cnt  (period_cnt),
      .wheel       (wheel_right),
      .pwm         (pwm_right),
      .dir         (dir_right),
      .dead        (dead_right)
   );

endmodule

// File: tb/tb_wheel_pwm_driver.sv
// Self-checking bench for wheel_pwm_driver with a per-period behavioural model.
module tb_wheel_pwm_driver;

   localparam int STEP   = 8;
   localparam int DEADP  = 2;
   localparam int PER    = 127;
   localparam int M_STOP = 0;
   localparam int M_FWD  = 1;
   localparam int M_REV  = 2;
   localparam int M_DEAD = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] wheel_left = 8'd0;
   logic [7:0] wheel_right = 8'd0;
   logic       pwm_left, dir_left, pwm_right, dir_right, period_start, busy;

   int n_pass = 0;
   int n_total = 0;

   int m_mode[2];
   int m_duty[2];
   int m_dead[2];
   int m_dir[2];

   int   o_cnt[2];
   logic o_dir[2];
   bit   o_dir_stable[2];
   logic o_busy;
   bit   o_busy_stable;
   bit   o_ps_ok;
   bit   o_dir_safe;
   logic prev_dir_l, prev_dir_r;

   wheel_pwm_driver #(.CLK_DIV(1), .SLEW_STEP(STEP), .DEAD_PERIODS(DEADP)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .wheel_left   (wheel_left),
      .wheel_right  (wheel_right),
      .pwm_left     (pwm_left),
      .dir_left     (dir_left),
      .pwm_right    (pwm_right),
      .dir_right    (dir_right),
      .period_start (period_start),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (one update per period) ----------------
   function automatic int toward(int cur, int goal);
      if (goal > cur) return (goal - cur > STEP) ? cur + STEP : goal;
      return (cur - goal > STEP) ? cur - STEP : goal;
   endfunction

   function automatic int exp_cnt(int ch);
      return (m_mode[ch] == M_FWD || m_mode[ch] == M_REV) ? m_duty[ch] : 0;
   endfunction

   function automatic int exp_busy();
      return (m_mode[0] == M_DEAD || m_mode[1] == M_DEAD) ? 1 : 0;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_mode[c] = M_STOP; m_duty[c] = 0; m_dead[c] = 0; m_dir[c] = 0;
      end
   endtask

   task automatic model_disable();
      for (int c = 0; c < 2; c++) begin
         m_mode[c] = M_STOP; m_duty[c] = 0; m_dead[c] = 0;
      end
   endtask

   task automatic model_step(input int ch, input logic [7:0] w);
      int v, mag, sgn, cur;
      v   = $signed(w);
      mag = (v < 0) ? -v : v;
      if (mag > 127) mag = 127;
      sgn = (v > 0) ? 1 : ((v < 0) ? -1 : 0);
      case (m_mode[ch])
         M_STOP: begin
            if (sgn != 0) begin
               m_mode[ch] = (sgn > 0) ? M_FWD : M_REV;
               m_dir[ch]  = (sgn < 0) ? 1 : 0;
               m_duty[ch] = toward(0, mag);
            end
         end
         M_FWD, M_REV: begin
            cur = (m_mode[ch] == M_FWD) ? 1 : -1;
            if (sgn == cur) begin
               m_duty[ch] = toward(m_duty[ch], mag);
            end else begin
               m_duty[ch] = toward(m_duty[ch], 0);
               if (m_duty[ch] == 0) begin
                  if (sgn == 0) m_mode[ch] = M_STOP;
                  else begin m_mode[ch] = M_DEAD; m_dead[ch] = DEADP; end
               end
            end
         end
         default: begin
            if (m_dead[ch] == 1) begin
               m_dead[ch] = 0;
               if (sgn != 0) begin
                  m_mode[ch] = (sgn > 0) ? M_FWD : M_REV;
                  m_dir[ch]  = (sgn < 0) ? 1 : 0;
                  m_duty[ch] = (mag < STEP) ? mag : STEP;
               end else begin
                  m_mode[ch] = M_STOP;
               end
            end else begin
               m_dead[ch] = m_dead[ch] - 1;
            end
         end
      endcase
   endtask

   // Watch one full period starting from the negedge of a period_start cycle.
   // mode 0: hold wl/wr; 1: left toggles +50/-50 mid-period; 2: both random mid-period.
   task automatic observe_period(input logic [7:0] wl, input logic [7:0] wr, input int mode);
      wheel_left  = (mode == 0) ? wl : 8'd50;
      wheel_right = (mode == 2) ? 8'($urandom) : wr;
      o_cnt[0] = 0; o_cnt[1] = 0;
      o_dir_stable[0] = 1; o_dir_stable[1] = 1;
      o_busy_stable = 1; o_ps_ok = 1; o_dir_safe = 1;
      for (int i = 1; i <= PER; i++) begin
         @(negedge clk);
         if (mode == 1 && i < 100) wheel_left = (i % 2 == 1) ? 8'hCE : 8'd50;
         if (mode == 2 && i < 100) begin
            wheel_left  = 8'($urandom);
            wheel_right = 8'($urandom);
         end
         if (i == 100) begin wheel_left = wl; wheel_right = wr; end
         o_cnt[0] += int'(pwm_left);
         o_cnt[1] += int'(pwm_right);
         if (i == 1) begin
            o_dir[0] = dir_left; o_dir[1] = dir_right; o_busy = busy;
         end else if (i < PER) begin
            if (dir_left !== o_dir[0])  o_dir_stable[0] = 0;
            if (dir_right !== o_dir[1]) o_dir_stable[1] = 0;
            if (busy !== o_busy)        o_busy_stable = 0;
         end
         if ((dir_left !== prev_dir_l && pwm_left !== 1'b0) ||
             (dir_right !== prev_dir_r && pwm_right !== 1'b0)) o_dir_safe = 0;
         prev_dir_l = dir_left;
         prev_dir_r = dir_right;
         if (period_start !== ((i == PER) ? 1'b1 : 1'b0)) o_ps_ok = 0;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int waited;
      reset = 1'b0; enable = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({pwm_left, dir_left, pwm_right, dir_right, period_start, busy} !== 6'b0)
         $display("FAIL reset_initial: got %b expected 000000",
                  {pwm_left, dir_left, pwm_right, dir_right, period_start, busy});
      else n_pass++;

      reset = 1'b1; enable = 1'b1; wheel_left = 8'd40; wheel_right = 8'h9C;
      repeat (200) @(negedge clk);
      n_total++;
      if (dir_right !== 1'b1) $display("FAIL reset_prerun_dir_r: got %b expected 1", dir_right);
      else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_total++;
      if ({pwm_left, dir_left, pwm_right, dir_right, period_start, busy} !== 6'b0)
         $display("FAIL reset_async: got %b expected 000000",
                  {pwm_left, dir_left, pwm_right, dir_right, period_start, busy});
      else n_pass++;

      wheel_left = 8'd0; wheel_right = 8'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_reset();
      prev_dir_l = 1'b0; prev_dir_r = 1'b0;
      waited = 0;
      while (period_start !== 1'b1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      n_total++;
      if (waited !== PER) $display("FAIL reset_first_start: got %0d cycles expected %0d", waited, PER);
      else n_pass++;
      if (period_start !== 1'b1) begin
         $display("FAIL reset_sync: no period_start within 300 cycles");
         $display("%0d/%0d checks passed", n_pass, n_total);
         $fatal(1, "lost period sync");
      end

      for (int k = 0; k < 2; k++) begin
         observe_period(8'd0, 8'd0, 0);
         n_total++;
         if (o_cnt[0] !== 0) $display("FAIL reset_idle_pwm_l[%0d]: got %0d expected 0", k, o_cnt[0]);
         else n_pass++;
         n_total++;
         if (!o_ps_ok) $display("FAIL reset_period_spacing[%0d]: got irregular expected %0d", k, PER);
         else n_pass++;
         model_step(0, 8'd0); model_step(1, 8'd0);
      end
   endtask

   task automatic test_ramp();
      int exp_tab[6] = '{8, 16, 24, 32, 40, 40};
      observe_period(8'd40, 8'd0, 0);
      model_step(0, 8'd40); model_step(1, 8'd0);
      for (int k = 0; k < 6; k++) begin
         observe_period(8'd40, 8'd0, 0);
         n_total++;
         if (o_cnt[0] !== exp_tab[k] || o_cnt[0] !== exp_cnt(0))
            $display("FAIL ramp_duty[%0d]: got %0d expected %0d", k, o_cnt[0], exp_tab[k]);
         else n_pass++;
         n_total++;
         if (o_dir[0] !== 1'b0 || !o_dir_stable[0])
            $display("FAIL ramp_dir[%0d]: got %b expected 0", k, o_dir[0]);
         else n_pass++;
         model_step(0, 8'd40); model_step(1, 8'd0);
      end
   endtask

   task automatic test_reverse();
      int cnt_tab[10]  = '{40, 32, 24, 16, 8, 0, 0, 8, 16, 24};
      int busy_tab[10] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
      int dir_tab[10]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
      for (int k = 0; k < 10; k++) begin
         observe_period(8'hE8, 8'd0, 0);
         n_total++;
         if (o_cnt[0] !== cnt_tab[k] || o_cnt[0] !== exp_cnt(0))
            $display("FAIL rev_duty[%0d]: got %0d expected %0d", k, o_cnt[0], cnt_tab[k]);
         else n_pass++;
         n_total++;
         if (int'(o_busy) !== busy_tab[k] || !o_busy_stable)
            $display("FAIL rev_busy[%0d]: got %b expected %0d", k, o_busy, busy_tab[k]);
         else n_pass++;
         n_total++;
         if (int'(o_dir[0]) !== dir_tab[k] || !o_dir_stable[0])
            $display("FAIL rev_dir[%0d]: got %b expected %0d", k, o_dir[0], dir_tab[k]);
         else n_pass++;
         n_total++;
         if (!o_dir_safe) $display("FAIL rev_dir_while_pwm[%0d]: got toggle with pwm=1 expected none", k);
         else n_pass++;
         model_step(0, 8'hE8); model_step(1, 8'd0);
      end
   endtask

   task automatic test_saturate();
      for (int k = 0; k < 20; k++) begin
         observe_period(8'hE8, 8'h80, 0);
         n_total++;
         if (o_cnt[1] !== exp_cnt(1)) $display("FAIL sat_neg_duty[%0d]: got %0d expected %0d", k, o_cnt[1], exp_cnt(1));
         else n_pass++;
         model_step(0, 8'hE8); model_step(1, 8'h80);
      end
      n_total++;
      if (o_cnt[1] !== 127 || o_dir[1] !== 1'b1)
         $display("FAIL sat_neg_full: got %0d/%b expected 127/1", o_cnt[1], o_dir[1]);
      else n_pass++;
      for (int k = 0; k < 40; k++) begin
         observe_period(8'hE8, 8'd127, 0);
         n_total++;
         if (o_cnt[1] !== exp_cnt(1) || !o_dir_safe)
            $display("FAIL sat_pos_duty[%0d]: got %0d expected %0d", k, o_cnt[1], exp_cnt(1));
         else n_pass++;
         model_step(0, 8'hE8); model_step(1, 8'd127);
      end
      n_total++;
      if (o_cnt[1] !== 127 || o_dir[1] !== 1'b0)
         $display("FAIL sat_pos_full: got %0d/%b expected 127/0", o_cnt[1], o_dir[1]);
      else n_pass++;
   endtask

   task automatic test_enable_dead();
      int k;
      k = 0;
      while (m_mode[0] != M_DEAD && k < 8) begin
         observe_period(8'd24, 8'd127, 0);
         model_step(0, 8'd24); model_step(1, 8'd127);
         k++;
      end
      n_total++;
      if (m_mode[0] != M_DEAD || m_dead[0] != DEADP)
         $display("FAIL en_reach_dead: got mode %0d expected %0d", m_mode[0], M_DEAD);
      else n_pass++;
      for (int i = 1; i <= PER; i++) begin
         @(negedge clk);
         if (i == 19) begin
            n_total++;
            if (busy !== 1'b1) $display("FAIL en_busy_before: got %b expected 1", busy);
            else n_pass++;
         end
         if (i == 20) enable = 1'b0;
         if (i == 22) begin
            n_total++;
            if (busy !== 1'b0) $display("FAIL en_busy_drop: got %b expected 0", busy);
            else n_pass++;
            n_total++;
            if (int'(dir_left) !== m_dir[0] || int'(dir_right) !== m_dir[1])
               $display("FAIL en_dir_hold: got %b%b expected %0d%0d", dir_left, dir_right, m_dir[0], m_dir[1]);
            else n_pass++;
            n_total++;
            if (pwm_right !== 1'b0 || pwm_left !== 1'b0)
               $display("FAIL en_pwm_off: got %b%b expected 00", pwm_left, pwm_right);
            else n_pass++;
         end
         if (i == 23) begin enable = 1'b1; wheel_left = 8'd16; wheel_right = 8'd0; end
         prev_dir_l = dir_left;
         prev_dir_r = dir_right;
      end
      n_total++;
      if (period_start !== 1'b1) $display("FAIL en_period_start: got %b expected 1", period_start);
      else n_pass++;
      model_disable();
      model_step(0, 8'd16); model_step(1, 8'd0);
      for (int j = 0; j < 2; j++) begin
         observe_period(8'd16, 8'd0, 0);
         n_total++;
         if (o_cnt[0] !== 8 * (j + 1) || o_dir[0] !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL en_restart[%0d]: got %0d/%b/%b expected %0d/0/0", j, o_cnt[0], o_dir[0], o_busy, 8 * (j + 1));
         else n_pass++;
         model_step(0, 8'd16); model_step(1, 8'd0);
      end
   endtask

   task automatic test_midperiod();
      logic [7:0] fin[2] = '{8'd50, 8'hCE};
      for (int k = 0; k < 2; k++) begin
         observe_period(fin[k], 8'd0, 1);
         n_total++;
         if (o_cnt[0] !== exp_cnt(0) || !o_dir_stable[0] || o_dir[0] !== 1'b0)
            $display("FAIL mid_toggle[%0d]: got %0d/%b expected %0d/0", k, o_cnt[0], o_dir[0], exp_cnt(0));
         else n_pass++;
         model_step(0, fin[k]); model_step(1, 8'd0);
      end
      observe_period(8'd0, 8'd0, 0);
      n_total++;
      if (o_cnt[0] !== 16 || o_cnt[0] !== exp_cnt(0))
         $display("FAIL mid_result: got %0d expected 16", o_cnt[0]);
      else n_pass++;
      model_step(0, 8'd0); model_step(1, 8'd0);
   endtask

   task automatic test_random();
      logic [7:0] wl, wr;
      wl = 8'd0; wr = 8'd0;
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(3, 0) != 0) wl = 8'($urandom);
         if ($urandom_range(3, 0) != 0) wr = 8'($urandom);
         observe_period(wl, wr, 2);
         n_total++;
         if (o_cnt[0] !== exp_cnt(0)) $display("FAIL rnd_duty_l[%0d]: got %0d expected %0d", k, o_cnt[0], exp_cnt(0));
         else n_pass++;
         n_total++;
         if (o_cnt[1] !== exp_cnt(1)) $display("FAIL rnd_duty_r[%0d]: got %0d expected %0d", k, o_cnt[1], exp_cnt(1));
         else n_pass++;
         n_total++;
         if (int'(o_dir[0]) !== m_dir[0] || int'(o_dir[1]) !== m_dir[1] || !o_dir_stable[0] || !o_dir_stable[1])
            $display("FAIL rnd_dir[%0d]: got %b%b expected %0d%0d", k, o_dir[0], o_dir[1], m_dir[0], m_dir[1]);
         else n_pass++;
         n_total++;
         if (int'(o_busy) !== exp_busy() || !o_busy_stable)
            $display("FAIL rnd_busy[%0d]: got %b expected %0d", k, o_busy, exp_busy());
         else n_pass++;
         n_total++;
         if (!o_ps_ok || !o_dir_safe)
            $display("FAIL rnd_timing[%0d]: got ps_ok=%0d dir_safe=%0d expected 1/1", k, o_ps_ok, o_dir_safe);
         else n_pass++;
         model_step(0, wl); model_step(1, wr);
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_reverse();
      test_saturate();
      test_enable_dead();
      test_midperiod();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
